// File: rtl/hazard_sequencer.sv
// Hazard-demonstration test controller: drives a one-bit-change vector sequence onto a
// two-input unit, counts f edges per settle window and checks settled f = b.
// Optional HAZARD_SEQ_SYNC_EN: f_in passes a two-flop synchronizer and each window grows by 2.
module hazard_sequencer #(
    parameter int unsigned SETTLE = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       f_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic [2:0] step,
    output logic [3:0] glitch_cnt,
    output logic [3:0] err_cnt,
    output logic       fail
);

`ifdef HAZARD_SEQ_SYNC_EN
    localparam int unsigned WIN = SETTLE + 2;
    logic f_meta_q;
    logic f_s_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_meta_q <= 1'b0;
            f_s_q    <= 1'b0;
        end else begin
            f_meta_q <= f_in;
            f_s_q    <= f_meta_q;
        end
    end
`else
    localparam int unsigned WIN = SETTLE;
    logic f_s_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) f_s_q <= 1'b0;
        else          f_s_q <= f_in;
    end
`endif

    localparam logic [8:0] WIN_LAST = 9'(WIN - 1);

    function automatic logic [1:0] vec_of(input logic [2:0] s);
        logic [1:0] v;
        case (s)
            3'd0:    v = 2'b00;
            3'd1:    v = 2'b01;
            3'd2:    v = 2'b11;
            3'd3:    v = 2'b01;
            3'd4:    v = 2'b00;
            3'd5:    v = 2'b10;
            3'd6:    v = 2'b11;
            default: v = 2'b10;
        endcase
        return v;
    endfunction

    function automatic logic exp_f(input logic [2:0] s);
        logic [1:0] v;
        v = vec_of(s);
        return v[0];
    endfunction

    // The vector before step 0 is the reset drive 00, so its expected f is 0.
    function automatic logic exp_edge(input logic [2:0] s);
        logic prev_f;
        prev_f = (s == 3'd0) ? 1'b0 : exp_f(s - 3'd1);
        return exp_f(s) ^ prev_f;
    endfunction

    // state   | meaning
    // IDLE    | waiting for start; outputs hold last run's results
    // APPLY   | drive vector for step, snapshot sampled f, arm window
    // WAIT    | settle window; count sampled f edges (saturating at 3)
    // CHECK   | score glitch / settled value, advance or finish
    // DONE    | one-cycle done pulse, back to IDLE
    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t     state_q;
    logic       a_q, b_q, busy_q, done_q, f_prev_q;
    logic [2:0] step_q;
    logic [3:0] glitch_q, err_q;
    logic [1:0] edge_q;
    logic [8:0] win_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            f_prev_q <= 1'b0;
            step_q   <= 3'd0;
            glitch_q <= 4'd0;
            err_q    <= 4'd0;
            edge_q   <= 2'd0;
            win_q    <= 9'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        glitch_q <= 4'd0;
                        err_q    <= 4'd0;
                        step_q   <= 3'd0;
                        busy_q   <= 1'b1;
                        state_q  <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    {a_q, b_q} <= vec_of(step_q);
                    f_prev_q   <= f_s_q;
                    edge_q     <= 2'd0;
                    win_q      <= WIN_LAST;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (f_s_q != f_prev_q) begin
                        f_prev_q <= f_s_q;
                        if (edge_q != 2'd3) edge_q <= edge_q + 2'd1;
                    end
                    if (win_q == 9'd0) state_q <= S_CHECK;
                    else               win_q   <= win_q - 9'd1;
                end
                S_CHECK: begin
                    if (edge_q > {1'b0, exp_edge(step_q)}) glitch_q <= glitch_q + 4'd1;
                    if (f_s_q != exp_f(step_q))            err_q    <= err_q + 4'd1;
                    if (step_q == 3'd7) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        step_q  <= step_q + 3'd1;
                        state_q <= S_APPLY;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign a_out      = a_q;
    assign b_out      = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign step       = step_q;
    assign glitch_cnt = glitch_q;
    assign err_cnt    = err_q;
    assign fail       = (glitch_q != 4'd0) || (err_q != 4'd0);

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: two instances (SETTLE=8 and SETTLE=1) driven by a
// selectable unit model (ideal, hazard pulse, stuck-at-0, stuck-at-1).
module tb_hazard_sequencer;
    localparam int S8 = 8;
    localparam int S1 = 1;
`ifdef HAZARD_SEQ_SYNC_EN
    localparam int LAT = 2;
    localparam int EXT = 2;
`else
    localparam int LAT = 1;
    localparam int EXT = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start8 = 1'b0;
    logic start1 = 1'b0;
    int unsigned mode = 0;

    logic f8, a8, b8, busy8, done8, fail8;
    logic [2:0] step8;
    logic [3:0] g8, e8;
    logic f1, a1, b1, busy1, done1, fail1;
    logic [2:0] step1;
    logic [3:0] g1, e1;
    logic ad8 = 1'b0;
    logic ad1 = 1'b0;

    int n_assert = 0;
    int n_fail = 0;
    logic [1:0] vtab [8] = '{2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ad8 <= a8;
        ad1 <= a1;
    end

    // 0: f=b, 1: f=b with a one-cycle low pulse when a toggles, 2: stuck 0, 3: stuck 1
    function automatic logic unit_f(input int unsigned m, input logic a, input logic b, input logic ad);
        case (m)
            0: return b;
            1: return b & ~(a ^ ad);
            2: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign f8 = unit_f(mode, a8, b8, ad8);
    assign f1 = unit_f(mode, a1, b1, ad1);

    hazard_sequencer #(.SETTLE(S8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .f_in(f8),
        .a_out(a8), .b_out(b8), .busy(busy8), .done(done8), .step(step8),
        .glitch_cnt(g8), .err_cnt(e8), .fail(fail8)
    );

    hazard_sequencer #(.SETTLE(S1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .f_in(f1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .step(step1),
        .glitch_cnt(g1), .err_cnt(e1), .fail(fail1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel != 0) ? busy1 : busy8;
    endfunction
    function automatic logic get_done(input int sel);
        return (sel != 0) ? done1 : done8;
    endfunction
    function automatic logic [2:0] get_step(input int sel);
        return (sel != 0) ? step1 : step8;
    endfunction
    function automatic logic [1:0] get_ab(input int sel);
        return (sel != 0) ? {a1, b1} : {a8, b8};
    endfunction
    function automatic logic [3:0] get_g(input int sel);
        return (sel != 0) ? g1 : g8;
    endfunction
    function automatic logic [3:0] get_e(input int sel);
        return (sel != 0) ? e1 : e8;
    endfunction
    function automatic logic get_fail(input int sel);
        return (sel != 0) ? fail1 : fail8;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) start1 = v;
        else          start8 = v;
    endtask

    // Expected counts from the vector table: a window of w cycles sees the unit output
    // delayed by LAT cycles; a hazard pulse sits in the first cycle after a toggles.
    function automatic void ref_counts(input int unsigned m, input int w, output int g, output int e);
        logic [1:0] prev, cur;
        int edges;
        g = 0;
        e = 0;
        prev = 2'b00;
        for (int s = 0; s < 8; s++) begin
            cur = vtab[s];
            if (m == 2 && cur[0] != 1'b0) e++;
            if (m == 3 && cur[0] != 1'b1) e++;
            if (m == 1 && cur[1] != prev[1] && prev[0] && cur[0]) begin
                edges = 0;
                if (LAT + 1 <= w) edges++;
                if (LAT + 2 <= w) edges++;
                if (edges > 0) g++;
                if (w == LAT) e++;
            end
            prev = cur;
        end
    endfunction

    task automatic chk_reset(input int sel, input string tag);
        chk({tag, "_ab"},   32'(get_ab(sel)),   32'd0);
        chk({tag, "_busy"}, 32'(get_busy(sel)), 32'd0);
        chk({tag, "_done"}, 32'(get_done(sel)), 32'd0);
        chk({tag, "_step"}, 32'(get_step(sel)), 32'd0);
        chk({tag, "_gl"},   32'(get_g(sel)),    32'd0);
        chk({tag, "_err"},  32'(get_e(sel)),    32'd0);
        chk({tag, "_fail"}, 32'(get_fail(sel)), 32'd0);
    endtask

    task automatic do_run(input int sel, input int unsigned m, input bit poke, input bit hold, input string tag);
        int w, g_exp, e_exp, n, limit;
        logic pb;
        logic [2:0] ps;
        bit poked, poke_active;
        w = ((sel != 0) ? S1 : S8) + EXT;
        ref_counts(m, w, g_exp, e_exp);
        limit = 1 + 8 * (2 + w) + 20;
        mode = m;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        if (!hold) set_start(sel, 1'b0);
        n = 1;
        pb = 1'b0;
        ps = 3'd0;
        poked = 1'b0;
        poke_active = 1'b0;
        while (n < limit && get_done(sel) !== 1'b1) begin
            chk({tag, "_busy"}, 32'(get_busy(sel)), 32'd1);
            if (pb && get_step(sel) == ps)
                chk({tag, "_vec"}, 32'(get_ab(sel)), 32'(vtab[get_step(sel)]));
            if (poke_active) begin
                set_start(sel, 1'b0);
                poke_active = 1'b0;
                chk({tag, "_poke_step"}, 32'(get_step(sel)), 32'd3);
                chk({tag, "_poke_gl"}, 32'(get_g(sel)), 32'd0);
            end else if (poke && !poked && pb && ps == 3'd3 && get_step(sel) == 3'd3) begin
                poked = 1'b1;
                poke_active = 1'b1;
                set_start(sel, 1'b1);
            end
            pb = get_busy(sel);
            ps = get_step(sel);
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(get_done(sel)), 32'd1);
        chk({tag, "_len"}, 32'(n), 32'(1 + 8 * (2 + w)));
        chk({tag, "_busy_done"}, 32'(get_busy(sel)), 32'd1);
        chk({tag, "_gl"}, 32'(get_g(sel)), 32'(g_exp));
        chk({tag, "_err"}, 32'(get_e(sel)), 32'(e_exp));
        chk({tag, "_fail"}, 32'(get_fail(sel)), 32'((g_exp != 0 || e_exp != 0) ? 1 : 0));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(get_done(sel)), 32'd0);
        chk({tag, "_idle"}, 32'(get_busy(sel)), 32'd0);
        chk({tag, "_hold_ab"}, 32'(get_ab(sel)), 32'd2);
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        chk_reset(0, "rst8");
        chk_reset(1, "rst1");
        reset_n = 1'b1;

        do_run(0, 0, 0, 0, "ideal8");
        do_run(0, 1, 0, 0, "hazard8");
        do_run(0, 2, 0, 0, "stuck0_8");
        do_run(1, 0, 0, 0, "ideal1");
        do_run(0, 0, 1, 0, "poke8");
        for (int i = 0; i < 6; i++)
            do_run(int'($urandom_range(0, 1)), $urandom_range(0, 3), 0, 0, "rand");
        do_run(1, 3, 0, 0, "stuck1_1");

        // start held through DONE relaunches a run once IDLE is re-entered
        do_run(0, 1, 0, 1, "hold8");
        @(negedge clk);
        chk("restart_busy", 32'(busy8), 32'd1);
        chk("restart_step", 32'(step8), 32'd0);
        chk("restart_gl", 32'(g8), 32'd0);
        start8 = 1'b0;

        k = 0;
        while (step8 != 3'd4 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reach_step4", 32'(step8), 32'd4);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy8), 32'd1);
        chk("pre_rst_gl", 32'(g8), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        chk_reset(0, "async8");
        chk_reset(1, "async1");
        @(negedge clk);
        reset_n = 1'b1;
        do_run(0, 1, 0, 0, "after_rst8");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
